line_buffer_3x3: RTL and testbench

LINE_BUFFER_3X3 -- requirements
Module: line_buffer_3x3

---
 rtl/line_buffer_3x3.sv | 148 ++++++++++++++
 tb/tb_line_buffer_3x3.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_3x3.sv
// rtl/line_buffer_3x3.sv - 3x3 sliding window generator over a raster pixel stream
//
// Purpose:
//   Holds the two previous image rows in line memories and builds a 3x3
//   window that slides one column per accepted pixel. A window strobe is
//   raised one clock after every pixel that completes a full window
//   (row >= 2 and col >= 2), so windows never wrap across row edges.
//
// Optional feature (macro LINE_BUFFER_3X3_FRAME_DONE_EN):
//   Adds frame_done_o. It pulses together with done_o for the last window
//   of each frame.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   done_i        pixel strobe, data_i valid this cycle
//   data_i[7:0]   raster-order pixel
//   d0_o..d8_o    window: d0..d2 top row, d3..d5 middle, d6..d8 bottom (d8 newest)
//   done_o        window valid strobe, one cycle per window
//   frame_done_o  last-window-of-frame strobe (macro builds only)

module line_buffer_3x3 #(
   parameter int ROWS = 7,
   parameter int COLS = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       done_i,
   input  logic [7:0] data_i,
   output logic [7:0] d0_o,
   output logic [7:0] d1_o,
   output logic [7:0] d2_o,
   output logic [7:0] d3_o,
   output logic [7:0] d4_o,
   output logic [7:0] d5_o,
   output logic [7:0] d6_o,
   output logic [7:0] d7_o,
   output logic [7:0] d8_o,
   output logic       done_o
`ifdef LINE_BUFFER_3X3_FRAME_DONE_EN
   ,
   output logic       frame_done_o
`endif
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);

   // Line memories: r_line0 holds the previous row, r_line1 the one before.
   logic [7:0]    r_line0 [COLS];
   logic [7:0]    r_line1 [COLS];

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [7:0]    r_win [9];
   logic          r_done;

   logic          w_col_last;
   logic          w_row_last;
   logic          w_win_ok;
   logic [7:0]    w_top;
   logic [7:0]    w_mid;

   assign w_col_last = (r_col == COL_LAST);
   assign w_row_last = (r_row == ROW_LAST);
   // A full window exists only once two prior rows and two prior columns
   // of the current row are available.
   assign w_win_ok   = (r_row >= ROW_TWO) && (r_col >= COL_TWO);
   assign w_top      = r_line1[r_col];
   assign w_mid      = r_line0[r_col];

   // Line memories are deliberately not reset: the window strobe is gated
   // by the counters, which restart at row 0 and cannot emit stale rows.
   always_ff @(posedge clk) begin
      if (done_i && !rst) begin
         r_line1[r_col] <= r_line0[r_col];
         r_line0[r_col] <= data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col  <= '0;
         r_row  <= '0;
         r_done <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            r_win[i] <= 8'd0;
         end
      end else begin
         r_done <= done_i && w_win_ok;
         if (done_i) begin
            // Shift each window row left and load the new right column
            // from the oldest row down to the incoming pixel.
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= w_top;
            r_win[3] <= r_win[4];
            r_win[4] <= r_win[5];
            r_win[5] <= w_mid;
            r_win[6] <= r_win[7];
            r_win[7] <= r_win[8];
            r_win[8] <= data_i;

            if (w_col_last) begin
               r_col <= '0;
               if (w_row_last) begin
                  r_row <= '0;
               end else begin
                  r_row <= r_row + 1'b1;
               end
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
      end
   end

`ifdef LINE_BUFFER_3X3_FRAME_DONE_EN
   logic r_frame_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= done_i && w_row_last && w_col_last;
      end
   end

   assign frame_done_o = r_frame_done;
`endif

   assign d0_o   = r_win[0];
   assign d1_o   = r_win[1];
   assign d2_o   = r_win[2];
   assign d3_o   = r_win[3];
   assign d4_o   = r_win[4];
   assign d5_o   = r_win[5];
   assign d6_o   = r_win[6];
   assign d7_o   = r_win[7];
   assign d8_o   = r_win[8];
   assign done_o = r_done;

endmodule

// File: tb/tb_line_buffer_3x3.sv
// tb/tb_line_buffer_3x3.sv - scoreboard bench for line_buffer_3x3
module tb_line_buffer_3x3;

   localparam int ROWS = 7;
   localparam int COLS = 7;

   logic       clk = 1'b0;
   logic       rst;
   logic       done_i;
   logic [7:0] data_i;
   logic [7:0] d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o;
   logic       done_o;
`ifdef LINE_BUFFER_3X3_FRAME_DONE_EN
   logic       frame_done_o;
`endif

   always #5 clk = ~clk;

   line_buffer_3x3 #(.ROWS(ROWS), .COLS(COLS)) dut (
      .clk    (clk),
      .rst    (rst),
      .done_i (done_i),
      .data_i (data_i),
      .d0_o   (d0_o),
      .d1_o   (d1_o),
      .d2_o   (d2_o),
      .d3_o   (d3_o),
      .d4_o   (d4_o),
      .d5_o   (d5_o),
      .d6_o   (d6_o),
      .d7_o   (d7_o),
      .d8_o   (d8_o),
      .done_o (done_o)
`ifdef LINE_BUFFER_3X3_FRAME_DONE_EN
      ,
      .frame_done_o (frame_done_o)
`endif
   );

   // Entry: {frame_done expected, d0..d8}
   logic [72:0] exp_q [$];
   int n_checks = 0;
   int n_pass   = 0;
   int n_acc    = 0;
   int n_win    = 0;
   int n_fd     = 0;
   int first_acc = -1;
   bit prev_di  = 1'b0;

   function automatic logic [71:0] win_now();
      return {d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o};
   endfunction

   // Output monitor: pops the scoreboard on every window strobe.
   always @(negedge clk) begin
      logic [72:0] e;
      logic [71:0] got;
      if (rst) begin
         n_acc   = 0;
         n_win   = 0;
         n_fd    = 0;
         prev_di = 1'b0;
         first_acc = -1;
      end else begin
         if (prev_di) n_acc++;
         if (done_o) begin
            n_checks++;
            if (!prev_di) $display("FAIL strobe: done_o=1 without accepted pixel (prev done_i=%0b, required 1)", prev_di);
            else n_pass++;
            if (n_win == 0) first_acc = n_acc;
            n_win++;
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL window_extra: got window %h, required no window", win_now());
            end else begin
               e   = exp_q.pop_front();
               got = win_now();
               if (got !== e[71:0]) $display("FAIL window: got %h, required %h", got, e[71:0]);
               else n_pass++;
`ifdef LINE_BUFFER_3X3_FRAME_DONE_EN
               n_checks++;
               if (frame_done_o !== e[72]) $display("FAIL frame_done: got %b, required %b", frame_done_o, e[72]);
               else n_pass++;
`endif
            end
         end
`ifdef LINE_BUFFER_3X3_FRAME_DONE_EN
         if (frame_done_o) n_fd++;
         if (frame_done_o && !done_o) begin
            n_checks++;
            $display("FAIL frame_done_alone: got 1 with done_o=0, required 0");
         end
`endif
         prev_di = done_i;
      end
   end

   task automatic do_reset();
      rst    = 1'b1;
      done_i = 1'b0;
      data_i = 8'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
   endtask

   // Sends the first npix pixels of a frame with value base + r*COLS + c,
   // inserting idle cycles with probability gap_pct percent.
   task automatic send_frame(input int base, input int gap_pct, input int npix);
      logic [72:0] e;
      int k;
      k = 0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (k >= npix) return;
            while (int'($urandom_range(99)) < gap_pct) begin
               @(posedge clk);
               #1 done_i = 1'b0;
               data_i = 8'($urandom);
            end
            if (r >= 2 && c >= 2) begin
               e[72] = (r == ROWS - 1) && (c == COLS - 1);
               for (int i = 0; i < 9; i++) begin
                  e[71 - 8*i -: 8] = 8'(base + (r - 2 + i / 3) * COLS + (c - 2 + i % 3));
               end
               exp_q.push_back(e);
            end
            @(posedge clk);
            #1 done_i = 1'b1;
            data_i = 8'(base + r * COLS + c);
            k++;
         end
      end
   endtask

   task automatic go_idle();
      @(posedge clk);
      #1 done_i = 1'b0;
      data_i = 8'($urandom);
   endtask

   task automatic drain(input string name);
      int budget;
      budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL %s_drain: %0d windows outstanding, required 0", name, exp_q.size());
      else n_pass++;
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      done_i = 1'b1;
      data_i = 8'hA5;
      repeat (3) @(negedge clk);
      n_checks++;
      if (win_now() !== 72'd0) $display("FAIL reset_window: got %h, required 0", win_now());
      else n_pass++;
      n_checks++;
      if (done_o !== 1'b0) $display("FAIL reset_done: got %b, required 0", done_o);
      else n_pass++;
`ifdef LINE_BUFFER_3X3_FRAME_DONE_EN
      n_checks++;
      if (frame_done_o !== 1'b0) $display("FAIL reset_frame_done: got %b, required 0", frame_done_o);
      else n_pass++;
`endif
   endtask

   task automatic test_single_frame();
      do_reset();
      send_frame(0, 0, ROWS * COLS);
      go_idle();
      drain("single");
      n_checks++;
      if (n_win != 25) $display("FAIL single_count: got %0d windows, required 25", n_win);
      else n_pass++;
      n_checks++;
      if (first_acc != 17) $display("FAIL single_first: first window after %0d pixels, required 17", first_acc);
      else n_pass++;
      repeat (5) @(negedge clk);
      n_checks++;
      if (win_now() !== {8'd32, 8'd33, 8'd34, 8'd39, 8'd40, 8'd41, 8'd46, 8'd47, 8'd48})
         $display("FAIL single_hold: got %h, required last window 32..48", win_now());
      else n_pass++;
      n_checks++;
      if (done_o !== 1'b0) $display("FAIL single_idle_done: got %b, required 0", done_o);
      else n_pass++;
`ifdef LINE_BUFFER_3X3_FRAME_DONE_EN
      n_checks++;
      if (n_fd != 1) $display("FAIL single_fd_count: got %0d, required 1", n_fd);
      else n_pass++;
`endif
   endtask

   task automatic test_random_gaps();
      do_reset();
      send_frame(0, 50, ROWS * COLS);
      go_idle();
      drain("gaps");
      n_checks++;
      if (n_win != 25) $display("FAIL gaps_count: got %0d windows, required 25", n_win);
      else n_pass++;
      n_checks++;
      if (first_acc != 17) $display("FAIL gaps_first: first window after %0d pixels, required 17", first_acc);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_frame(0, 0, ROWS * COLS);
      send_frame(100, 0, ROWS * COLS);
      go_idle();
      drain("b2b");
      n_checks++;
      if (n_win != 50) $display("FAIL b2b_count: got %0d windows, required 50", n_win);
      else n_pass++;
`ifdef LINE_BUFFER_3X3_FRAME_DONE_EN
      n_checks++;
      if (n_fd != 2) $display("FAIL b2b_fd_count: got %0d, required 2", n_fd);
      else n_pass++;
`endif
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      send_frame(0, 0, 21);
      go_idle();
      @(posedge clk);
      n_checks++;
      if (n_win != 5) $display("FAIL mid_pre_count: got %0d windows, required 5", n_win);
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (win_now() !== 72'd0 || done_o !== 1'b0)
         $display("FAIL mid_async_clear: got window %h done %b, required 0", win_now(), done_o);
      else n_pass++;
      done_i = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (win_now() !== 72'd0 || done_o !== 1'b0)
         $display("FAIL mid_reset_hold: got window %h done %b, required 0", win_now(), done_o);
      else n_pass++;
      @(posedge clk);
      #1 rst = 1'b0;
      done_i = 1'b0;
      exp_q.delete();
      send_frame(50, 0, ROWS * COLS);
      go_idle();
      drain("mid");
      n_checks++;
      if (n_win != 25) $display("FAIL mid_count: got %0d windows, required 25", n_win);
      else n_pass++;
      n_checks++;
      if (first_acc != 17) $display("FAIL mid_first: first window after %0d pixels, required 17", first_acc);
      else n_pass++;
   endtask

   initial begin
      rst    = 1'b1;
      done_i = 1'b0;
      data_i = 8'd0;
      test_reset();
      test_single_frame();
      test_random_gaps();
      test_back_to_back();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit, required completion");
      $fatal(1);
   end

endmodule
